// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StTrap
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's ALUOp plus instruction funct fields to an ALU operation.
module aludec
    import riscv_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = 3'b000;
        case (ALUOp)
            ALUOP_ADD: ALUControl = 3'b000;
            ALUOP_SUB: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    // funct7b5 only selects sub for R-type; for I-type it is immediate bits
                    3'b000:  ALUControl = (opb5 & funct7b5) ? 3'b001 : 3'b000;
                    3'b001:  ALUControl = 3'b110;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b101:  ALUControl = 3'b111;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences the shared datapath and traps on
// undecodable opcodes.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       Illegal
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;
    logic       rdy;

    assign rdy = MemReady | ~USE_MEM_READY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        alu_op    = ALUOP_ADD;
        branch    = 1'b0;
        pc_update = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                pc_update = rdy;
                if (rdy) state_d = StDecode;
            end
            StDecode: begin
                // Precompute PC-relative target from OldPC while the opcode is decoded
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_RTYPE:          state_d = StExecR;
                    OP_ITYPE:          state_d = StExecI;
                    OP_BRANCH:         state_d = StBeq;
                    OP_JAL:            state_d = StJal;
                    default:           state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (rdy) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = rdy;
                if (rdy) state_d = StFetch;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = StFetch;
            end
            StBeq: begin
                ALUSrcA   = 2'b10;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                InstrDone = 1'b1;
                state_d   = StFetch;
            end
            StJal: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StTrap: begin
                Illegal = 1'b1;
            end
            default: state_d = StFetch;
        endcase
        PCWrite = pc_update | (branch & Zero);
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    aludec u_aludec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUOp      (alu_op),
        .ALUControl (ALUControl)
    );

endmodule
